// File: rtl/bram_pkg.sv
// Shared definitions for the sp_bram requester front end: FSM state encoding,
// response buffer depth and the modulo-3 pointer increment.
package bram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int RSP_DEPTH = 3;

    // Advance a response-buffer pointer, wrapping 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/sp_bram.sv
// Single-port synchronous RAM: one registered read per cycle, write on we_i.
// Read data for the address sampled at a clock edge is valid after that edge.
module sp_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // Write port and registered read port share the single address.
    // NOTE: the storage array has no reset so it maps onto block RAM; contents
    // are undefined until written. Non-blocking assignments keep the read
    // returning the pre-edge contents (read-first) without ordering hazards.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/sp_bram_port.sv
// Requester-side front end for sp_bram. Requests arrive on a valid/ready
// handshake; read data returns in order through a 3-entry response buffer
// whose free slots are handed out as credits, so consumer backpressure can
// never overflow it.
// Optional feature: define BRAM_PORT_CLEAR_EN to zero the whole RAM after
// reset (one word per cycle, busy=1) before requests are accepted.
module sp_bram_port
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    state_e                state_q;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  req_fire;
    logic                  rd_fire;
    logic                  push;
    logic                  pop;
    logic [2:0]            credits_used;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];

`ifdef BRAM_PORT_CLEAR_EN
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

    // State and clear pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Sweep every address with a zero write, then settle in RUN for good.
    // NOTE: every signal driven here gets a default first so no latch is
    // inferred on paths the case statement does not assign.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    assign clr_addr = clr_ptr_q;
`else
    assign state_q  = ST_RUN;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = (state_q == ST_CLEAR);

    // A request may only take a slot the response buffer can still hold once
    // every outstanding read has landed; held low while reset is asserted.
    assign credits_used = {1'b0, count_q} + {2'b00, rd_inflight_q};
    assign req_ready    = rst_n && (state_q == ST_RUN) && (credits_used < 3'(RSP_DEPTH));

    assign req_fire = req_valid && req_ready;
    assign rd_fire  = req_fire && !req_we;
    assign push     = rd_inflight_q;
    assign pop      = rsp_valid && rsp_ready;

    // RAM port: the clear sweep owns it in CLEAR, the accepted request in RUN.
    assign ram_we    = clr_we || (req_fire && req_we);
    assign ram_addr  = busy ? clr_addr : req_addr;
    assign ram_wdata = busy ? '0 : req_wdata;

    sp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Next-state for the in-flight flag, buffer pointers and occupancy.
    always_comb begin
        rd_inflight_d = rd_fire;
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d       = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Response buffer registers; the small entry array is reset so the
    // presented read data is 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            count_q       <= 2'd0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            rd_inflight_q <= rd_inflight_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                if (push && (wr_ptr_q == 2'(i))) begin
                    fifo_mem_q[i] <= ram_rdata;
                end
            end
        end
    end

    // Response outputs come straight from registers: no input-to-output path.
    always_comb begin
        rsp_rdata = fifo_mem_q[0];
        case (rd_ptr_q)
            2'd1:    rsp_rdata = fifo_mem_q[1];
            2'd2:    rsp_rdata = fifo_mem_q[2];
            default: rsp_rdata = fifo_mem_q[0];
        endcase
    end

    assign rsp_valid = (count_q != 2'd0);

endmodule
